// File: rtl/fp16_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_pkg                                                                 |
// | Shared fp16 constants, field helpers and the scheduler stage-1 record.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fp16_pkg;

    localparam int          FP16_W       = 16;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
    localparam int          FP16_ID_W    = 3;

    typedef struct packed {
        logic                 valid;
        logic [FP16_W-1:0]    a;
        logic [FP16_W-1:0]    b;
        logic [FP16_ID_W-1:0] id;
    } fp16_s1_t;

    function automatic logic fp16_is_nan(input logic [FP16_W-1:0] x);
        return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic fp16_is_inf(input logic [FP16_W-1:0] x);
        return (x[14:10] == FP16_EXP_MAX) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic fp16_is_zero(input logic [FP16_W-1:0] x);
        return (x[14:0] == 15'd0);
    endfunction

    // Subnormals share the scale of exponent 1 with a zero hidden bit.
    function automatic logic [4:0] fp16_eff_exp(input logic [FP16_W-1:0] x);
        return (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_mul_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_mul_unit                                                            |
// | Combinational IEEE fp16 multiply, RNE, subnormals, canonical NaN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp16_mul_unit
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a_i,
    input  logic [FP16_W-1:0] b_i,
    output logic [FP16_W-1:0] y_o
);

    logic        w_sign;
    logic [10:0] w_ma;
    logic [10:0] w_mb;
    logic [21:0] w_prod;
    logic [21:0] w_norm;
    logic [4:0]  w_lz;
    int          w_bexp;
    int          w_shift;
    logic [63:0] w_ext;
    logic [21:0] w_sig;
    logic        w_guard;
    logic        w_sticky;
    logic        w_rnd;
    logic [4:0]  w_expf;
    logic [14:0] w_mag;

    always_comb begin
        w_sign = a_i[15] ^ b_i[15];
        w_ma   = {|a_i[14:10], a_i[9:0]};
        w_mb   = {|b_i[14:10], b_i[9:0]};
        w_prod = 22'(w_ma) * 22'(w_mb);

        w_lz = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (w_prod[i]) begin
                w_lz = 5'(21 - i);
            end
        end
        w_norm = w_prod << w_lz;

        // Biased result exponent with the leading one at bit 21.
        w_bexp = int'(fp16_eff_exp(a_i)) + int'(fp16_eff_exp(b_i)) - 14 - int'(w_lz);
        if (w_bexp < 1) begin
            w_shift = ((1 - w_bexp) > 40) ? 40 : (1 - w_bexp);
        end else begin
            w_shift = 0;
        end

        w_ext    = {w_norm, 42'd0} >> w_shift;
        w_sig    = w_ext[63:42];
        w_guard  = w_sig[10];
        w_sticky = (|w_sig[9:0]) | (|w_ext[41:0]);
        w_rnd    = w_guard & (w_sticky | w_sig[11]);
        // Hidden bit survives only when no denormalising shift happened.
        w_expf   = w_sig[21] ? w_bexp[4:0] : 5'd0;
        w_mag    = {w_expf, w_sig[20:11]} + 15'(w_rnd);

        if (fp16_is_nan(a_i) || fp16_is_nan(b_i) ||
            (fp16_is_inf(a_i) && fp16_is_zero(b_i)) ||
            (fp16_is_zero(a_i) && fp16_is_inf(b_i))) begin
            y_o = FP16_QNAN;
        end else if (fp16_is_inf(a_i) || fp16_is_inf(b_i)) begin
            y_o = {w_sign, FP16_EXP_MAX, 10'd0};
        end else if (fp16_is_zero(a_i) || fp16_is_zero(b_i)) begin
            y_o = {w_sign, 15'd0};
        end else if (w_bexp >= 31) begin
            y_o = {w_sign, FP16_EXP_MAX, 10'd0};
        end else begin
            y_o = {w_sign, w_mag};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_rr_arbiter                                                          |
// | Combinational round-robin pick: first valid requester from rr_ptr up.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp16_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [IDW-1:0]  grant_o,
    output logic            any_valid_o
);

    int w_idx;

    // Scan from the farthest slot back to rr_ptr so the nearest valid wins.
    always_comb begin
        grant_o = '0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(rr_ptr_i) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req_valid_i[w_idx]) begin
                grant_o = IDW'(w_idx);
            end
        end
        any_valid_o = |req_valid_i;
    end

endmodule
`default_nettype wire

// File: rtl/fp16_mul_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_mul_sched                                                           |
// | Round-robin scheduler sharing one fp16 multiplier through a 2-stage      |
// | pipe with a tagged, backpressured response. FP16_MUL_SCHED_STATS_EN      |
// | builds the response/NaN counters.                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp16_mul_sched
    import fp16_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [FP16_W*NREQ-1:0] req_a,
    input  logic [FP16_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [FP16_W-1:0]      rsp_y,
    output logic [IDW-1:0]         rsp_id,
    input  logic                   rsp_ready,
    output logic                   busy,
    output logic [15:0]            stat_ops,
    output logic [15:0]            stat_nan
);

    fp16_s1_t          s1_q;
    fp16_s1_t          s1_d;
    logic              s2_valid_q;
    logic [FP16_W-1:0] s2_y_q;
    logic [IDW-1:0]    s2_id_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    rr_ptr_d;

    logic              w_adv1;
    logic              w_adv2;
    logic              w_any;
    logic              w_take;
    logic [IDW-1:0]    w_grant;
    logic [FP16_W-1:0] w_mul_y;

    fp16_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (w_grant),
        .any_valid_o (w_any)
    );

    fp16_mul_unit u_mul (
        .a_i (s1_q.a),
        .b_i (s1_q.b),
        .y_o (w_mul_y)
    );

    assign w_adv2 = !s2_valid_q | rsp_ready;
    assign w_adv1 = !s1_q.valid | w_adv2;
    // Ready is forced low while reset is held so nothing looks accepted.
    assign w_take = w_any & w_adv1 & !rst;

    always_comb begin
        req_ready = '0;
        if (w_take) begin
            req_ready[w_grant] = 1'b1;
        end

        s1_d.valid = w_any;
        s1_d.a     = req_a[FP16_W*int'(w_grant) +: FP16_W];
        s1_d.b     = req_b[FP16_W*int'(w_grant) +: FP16_W];
        s1_d.id    = FP16_ID_W'(w_grant);

        if (int'(w_grant) == NREQ - 1) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = w_grant + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_id_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            if (w_adv1) begin
                s1_q <= s1_d;
            end
            if (w_adv2) begin
                s2_valid_q <= s1_q.valid;
                s2_y_q     <= w_mul_y;
                s2_id_q    <= s1_q.id[IDW-1:0];
            end
            if (w_take) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_y     = s2_y_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_q.valid | s2_valid_q;

`ifdef FP16_MUL_SCHED_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_nan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= 16'd0;
            stat_nan_q <= 16'd0;
        end else if (s2_valid_q && rsp_ready) begin
            stat_ops_q <= stat_ops_q + 16'd1;
            if (fp16_is_nan(s2_y_q)) begin
                stat_nan_q <= stat_nan_q + 16'd1;
            end
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_nan = stat_nan_q;
`else
    assign stat_ops = 16'd0;
    assign stat_nan = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_mul_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp16_mul_sched                                                        |
// | Scenario tasks plus a queue scoreboard fed by an independent fp16 model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fp16_mul_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [16*NREQ-1:0]   req_a = '0;
    logic [16*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [15:0]          rsp_y;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_ready = 1'b0;
    logic                 busy;
    logic [15:0]          stat_ops;
    logic [15:0]          stat_nan;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    y;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_acc = 0;
    int   n_rsp = 0;

    fp16_mul_sched #(
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .stat_ops  (stat_ops),
        .stat_nan  (stat_nan)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (via double precision) ----------------
    function automatic real f16_to_real(input logic [15:0] x);
        int  e;
        real m;
        e = int'(x[14:10]);
        if (e == 0) m = real'(int'(x[9:0])) * (2.0 ** (-24));
        else        m = real'(1024 + int'(x[9:0])) * (2.0 ** (e - 25));
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic         s;
        logic         an, bn, ai, bi, az, bz;
        real          r;
        logic [63:0]  bits;
        int           e, u, sh, ex;
        logic [127:0] m, kept, rem, half, val;
        s  = a[15] ^ b[15];
        an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        az = (a[14:0] == 0);
        bz = (b[14:0] == 0);
        if (an || bn || (ai && bz) || (az && bi)) return 16'h7E00;
        if (ai || bi) return {s, 15'h7C00};
        if (az || bz) return {s, 15'h0000};
        r    = f16_to_real(a) * f16_to_real(b);
        bits = $realtobits(r);
        e    = int'(bits[62:52]) - 1023;
        if (e > 15) return {s, 15'h7C00};
        m    = {75'd0, 1'b1, bits[51:0]};
        u    = (e >= -14) ? (e - 10) : -24;
        sh   = u - (e - 52);
        kept = m >> sh;
        rem  = m - (kept << sh);
        half = 128'd1 << (sh - 1);
        val  = kept;
        if (rem > half || (rem == half && kept[0])) val = kept + 1;
        if (e >= -14) begin
            ex = e + 15;
            if (val == 128'd2048) begin
                val = 128'd1024;
                ex  = ex + 1;
            end
            if (ex >= 31) return {s, 15'h7C00};
            return {s, 5'(ex), val[9:0]};
        end
        return {s, val[14:0]};
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            1: v[14:10] = 5'($urandom_range(10, 20));
            2: v[14:10] = 5'($urandom_range(0, 2));
            3: v[14:10] = 5'($urandom_range(3, 9));
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL sb_unexpected: got id=%0d y=%h, required no response", rsp_id, rsp_y);
                end else begin
                    sb_e = sb_q.pop_front();
                    if (rsp_y !== sb_e.y || rsp_id !== sb_e.id) begin
                        n_mis++;
                        $display("FAIL sb_rsp: got id=%0d y=%h, required id=%0d y=%h",
                                 rsp_id, rsp_y, sb_e.id, sb_e.y);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({IDW'(i), ref_mul(req_a[16*i +: 16], req_b[16*i +: 16])});
                    n_acc++;
                end
            end
        end
    end

    // ---------------- helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        sb_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (sb_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = '1;
        tick();
        tick();
        n_cmp += 7;
        if (rsp_valid !== 1'b0) begin n_mis++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        if (rsp_y !== 16'h0)    begin n_mis++; $display("FAIL rst_rsp_y: got %h, required 0000", rsp_y); end
        if (rsp_id !== '0)      begin n_mis++; $display("FAIL rst_rsp_id: got %0d, required 0", rsp_id); end
        if (busy !== 1'b0)      begin n_mis++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (req_ready !== '0)   begin n_mis++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
        if (stat_ops !== 16'd0) begin n_mis++; $display("FAIL rst_stat_ops: got %0d, required 0", stat_ops); end
        if (stat_nan !== 16'd0) begin n_mis++; $display("FAIL rst_stat_nan: got %0d, required 0", stat_nan); end
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rsp_ready      = 1'b1;
        req_a[32 +: 16] = 16'h3E00;
        req_b[32 +: 16] = 16'h3E00;
        req_valid      = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_mis++; $display("FAIL single_grant: got %b, required 0100", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_mis++; $display("FAIL single_lat1: got valid=%b busy=%b, required valid=0 busy=1", rsp_valid, busy);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_y !== 16'h4080 || rsp_id !== 2'd2) begin
            n_mis++; $display("FAIL single_rsp: got valid=%b y=%h id=%0d, required valid=1 y=4080 id=2",
                              rsp_valid, rsp_y, rsp_id);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_mis++; $display("FAIL single_pulse: got valid=%b busy=%b, required valid=0 busy=0", rsp_valid, busy);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'h3C00;
            req_b[16*i +: 16] = 16'h4000 + 16'(i);
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) req_valid = '0;
            @(negedge clk);
            if (c < 6) begin
                n_cmp++;
                if (req_ready !== (NREQ'(1) << order[c])) begin
                    n_mis++; $display("FAIL rr_grant%0d: got %b, required requester %0d", c, req_ready, order[c]);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[c-2])) begin
                    n_mis++; $display("FAIL rr_rsp%0d: got valid=%b id=%0d, required valid=1 id=%0d",
                                      c, rsp_valid, rsp_id, order[c-2]);
                end
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_mis++; $display("FAIL rr_end: got valid=%b, required 0", rsp_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        int          acc0;
        logic [15:0] y0;
        logic [IDW-1:0] id0;
        bit          ok;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'h4000 + 16'(i * 256);
            req_b[16*i +: 16] = 16'hBC00;
        end
        acc0      = n_acc;
        rsp_ready = 1'b0;
        req_valid = '1;
        tick();
        tick();
        tick();
        y0  = rsp_y;
        id0 = rsp_id;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== '0 || rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_y !== y0 || rsp_id !== id0) begin
                n_mis++; $display("FAIL bp_hold%0d: got ready=%b valid=%b busy=%b y=%h id=%0d, required 0000/1/1/%h/%0d",
                                  c, req_ready, rsp_valid, busy, rsp_y, rsp_id, y0, id0);
            end
            tick();
        end
        n_cmp++;
        if (n_acc - acc0 !== 2) begin n_mis++; $display("FAIL bp_count: got %0d accepted, required 2", n_acc - acc0); end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL bp_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_special();
        logic [15:0] ta [5] = '{16'h3E00, 16'h7C00, 16'h7C00, 16'h0400, 16'h3C00};
        logic [15:0] tb [5] = '{16'h3E00, 16'h0000, 16'hC000, 16'h0400, 16'h7E01};
        logic [15:0] ty [5] = '{16'h4080, 16'h7E00, 16'hFC00, 16'h0000, 16'h7E00};
        logic [15:0] nan0;
        nan0      = stat_nan;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_a[15:0] = ta[k];
            req_b[15:0] = tb[k];
            req_valid   = 4'b0001;
            tick();
            req_valid = '0;
            for (int w = 0; w < 5; w++) begin
                @(negedge clk);
                if (rsp_valid) break;
                tick();
            end
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_y !== ty[k]) begin
                n_mis++; $display("FAIL special%0d: %h*%h got valid=%b y=%h, required %h",
                                  k, ta[k], tb[k], rsp_valid, rsp_y, ty[k]);
            end
            tick();
        end
        n_cmp++;
`ifdef FP16_MUL_SCHED_STATS_EN
        if (stat_nan - nan0 !== 16'd2) begin n_mis++; $display("FAIL special_nan: got +%0d, required +2", stat_nan - nan0); end
`else
        if (stat_nan !== 16'd0 || nan0 !== 16'd0) begin n_mis++; $display("FAIL special_nan: got %0d, required 0", stat_nan); end
`endif
    endtask

    task automatic test_random();
        logic [NREQ-1:0] acc;
        bit ok;
        acc       = '1;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid[i]      = 1'b1;
                        req_a[16*i +: 16] = rnd_op();
                        req_b[16*i +: 16] = rnd_op();
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = req_valid & req_ready;
            n_cmp++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
                n_mis++; $display("FAIL rand_ready%0d: got ready=%b valid=%b, required onehot0 within valid",
                                  c, req_ready, req_valid);
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL rand_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        rsp_ready = 1'b0;
        req_valid = '1;
        tick();
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1 || rsp_valid !== 1'b1) begin
            n_mis++; $display("FAIL rmid_full: got busy=%b valid=%b, required 1/1", busy, rsp_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || stat_ops !== 16'd0 || stat_nan !== 16'd0) begin
            n_mis++; $display("FAIL rmid_async: got valid=%b busy=%b ready=%b ops=%0d nan=%0d, required all 0",
                              rsp_valid, busy, req_ready, stat_ops, stat_nan);
        end
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_mis++; $display("FAIL rmid_first: got %b, required 0001", req_ready); end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(ok);
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL rmid_drain: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_stats();
        int rsp0;
        bit ok;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'h3C00;
            req_b[16*i +: 16] = 16'h4000 + 16'(i);
        end
        rsp0      = n_rsp;
        rsp_ready = 1'b1;
`ifdef FP16_MUL_SCHED_STATS_EN
        begin
            int target;
            int cnt;
            target    = 65537;
            cnt       = 0;
            req_valid = '1;
            for (int c = 0; c < target + 100; c++) begin
                @(negedge clk);
                if (|(req_valid & req_ready)) cnt++;
                if (cnt >= target) break;
                tick();
            end
            tick();
            req_valid = '0;
            wait_idle(ok);
            n_cmp++;
            if (!ok || n_rsp - rsp0 !== target) begin
                n_mis++; $display("FAIL stats_count: got %0d responses, required %0d", n_rsp - rsp0, target);
            end
            n_cmp++;
            if (stat_ops !== 16'd1 || stat_nan !== 16'd0) begin
                n_mis++; $display("FAIL stats_wrap: got ops=%0d nan=%0d, required ops=1 nan=0", stat_ops, stat_nan);
            end
        end
`else
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_cmp++;
            if (stat_ops !== 16'd0 || stat_nan !== 16'd0) begin
                n_mis++; $display("FAIL stats_off%0d: got ops=%0d nan=%0d, required 0/0", c, stat_ops, stat_nan);
            end
            tick();
        end
        req_valid = '0;
        wait_idle(ok);
        n_cmp++;
        if (!ok || n_rsp - rsp0 < 38) begin
            n_mis++; $display("FAIL stats_off_flow: got %0d responses, required at least 38", n_rsp - rsp0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_special();
        test_random();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
